// File: rtl/bkt_lvl_search_if.sv
// Request/response bundle between the conflict controller and the backtrack-level finder.
interface bkt_lvl_search_if #(
    parameter int NUM_LVLS         = 8,
    parameter int WIDTH_LVL_STATES = 11,
    parameter int WIDTH_LVL        = 16
);
    logic                                 start_i;
    logic [WIDTH_LVL-1:0]                 max_lvl_i;
    logic [WIDTH_LVL_STATES*NUM_LVLS-1:0] lvl_states_i;
    logic                                 busy_o;
    logic                                 done_o;
    logic                                 found_o;
    logic                                 err_o;
    logic [WIDTH_LVL-1:0]                 bkt_lvl_o;
    logic [9:0]                           bkt_bin_o;
    logic                                 apply_bkt_o;

    modport master (
        output start_i, max_lvl_i, lvl_states_i,
        input  busy_o, done_o, found_o, err_o, bkt_lvl_o, bkt_bin_o, apply_bkt_o
    );

    modport slave (
        input  start_i, max_lvl_i, lvl_states_i,
        output busy_o, done_o, found_o, err_o, bkt_lvl_o, bkt_bin_o, apply_bkt_o
    );
endinterface

// File: rtl/bkt_lvl_search.sv
// Sequential backtrack-level finder: walks a snapshot of the level states from
// max_lvl downward, one level per cycle, and reports the first non-backtracked level above 0.
module bkt_lvl_search #(
    parameter int NUM_LVLS         = 8,
    parameter int WIDTH_LVL_STATES = 11,
    parameter int WIDTH_LVL        = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    bkt_lvl_search_if.slave        bus
);
    localparam int IW = $clog2(NUM_LVLS);
    localparam int W  = WIDTH_LVL_STATES;

    typedef enum logic [1:0] {IDLE, SCAN, RESULT} state_t;

    state_t                 state, state_nxt;
    logic [NUM_LVLS*W-1:0]  snap;
    logic [IW-1:0]          idx;
    logic                   found_q, err_q;
    logic [WIDTH_LVL-1:0]   lvl_q;
    logic [9:0]             bin_q;

    logic [W-1:0]           lvl_st [NUM_LVLS];
    logic [W-1:0]           cur;
    logic                   start_err;
    logic                   hit, last;

    // Level 0 sits in the MSB slice of the packed state vector.
    for (genvar g = 0; g < NUM_LVLS; g++) begin : g_lvl
        assign lvl_st[g] = snap[(NUM_LVLS-1-g)*W +: W];
    end

    assign cur       = lvl_st[idx];
    assign last      = (idx == '0);
    assign hit       = !cur[0] && !last;
    // Full-width compare so large max_lvl values are never aliased into the window.
    assign start_err = (bus.max_lvl_i >= WIDTH_LVL'(NUM_LVLS));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start_i) state_nxt = start_err ? RESULT : SCAN;
            SCAN:    if (hit || last) state_nxt = RESULT;
            RESULT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            snap    <= '0;
            idx     <= '0;
            found_q <= 1'b0;
            err_q   <= 1'b0;
            lvl_q   <= '0;
            bin_q   <= '0;
        end else begin
            case (state)
                IDLE: if (bus.start_i) begin
                    snap <= bus.lvl_states_i;
                    idx  <= bus.max_lvl_i[IW-1:0];
                    if (start_err) begin
                        found_q <= 1'b0;
                        err_q   <= 1'b1;
                        lvl_q   <= '0;
                        bin_q   <= '0;
                    end
                end
                SCAN: begin
                    if (hit) begin
                        found_q <= 1'b1;
                        err_q   <= 1'b0;
                        lvl_q   <= WIDTH_LVL'(idx);
                        bin_q   <= cur[10:1];
                    end else if (last) begin
                        found_q <= 1'b0;
                        err_q   <= 1'b0;
                        lvl_q   <= '0;
                        bin_q   <= '0;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.busy_o      = (state == SCAN);
        bus.done_o      = (state == RESULT);
        bus.apply_bkt_o = (state == RESULT) && found_q;
        bus.found_o     = found_q;
        bus.err_o       = err_q;
        bus.bkt_lvl_o   = lvl_q;
        bus.bkt_bin_o   = bin_q;
    end
endmodule
